// File: rtl/morse_pkg.sv
// morse_pkg: state encoding, symbol values and default timing shared by the Morse game blocks
package morse_pkg;
    typedef enum logic [1:0] {IDLE, PRESS, GAP} morse_state_t;
    localparam logic SYM_DOT = 1'b0;
    localparam logic SYM_DASH = 1'b1;
    localparam int DEF_DASH_TICKS = 3;
    localparam int DEF_LETTER_GAP_TICKS = 3;
    localparam int DEF_MAX_SYMBOLS = 5;
    localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/morse_tick_counter.sv
// morse_tick_counter: saturating tick counter with synchronous clear
module morse_tick_counter
    import morse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    // clear has priority over counting; the count holds at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: times key presses/gaps in ticks, classifies dots/dashes and assembles letter codes
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int DASH_TICKS       = DEF_DASH_TICKS,
    parameter int LETTER_GAP_TICKS = DEF_LETTER_GAP_TICKS,
    parameter int MAX_SYMBOLS      = DEF_MAX_SYMBOLS,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   key_in,
    output logic                   symbol_valid,
    output logic                   symbol_is_dash,
    output logic [MAX_SYMBOLS-1:0] code,
    output logic [2:0]             code_len,
    output logic                   letter_valid,
    output logic                   overflow
);
    if (LETTER_GAP_TICKS > 2**CNT_W - 1 || DASH_TICKS > 2**CNT_W - 1) begin : g_cnt_chk
        $error("tick thresholds do not fit in the CNT_W counter");
    end
    if (LETTER_GAP_TICKS < 1 || MAX_SYMBOLS > 7) begin : g_len_chk
        $error("letter gap must be at least one tick and code_len holds at most 7 symbols");
    end

    morse_state_t     state;
    logic             key_d;
    logic             rise;
    logic             fall;
    logic             is_dash;
    logic             gap_done;
    logic [CNT_W-1:0] cnt;

    assign rise     = key_in & ~key_d;
    assign fall     = ~key_in & key_d;
    assign is_dash  = (cnt >= CNT_W'(DASH_TICKS)) ? SYM_DASH : SYM_DOT;
    assign gap_done = tick && cnt >= CNT_W'(LETTER_GAP_TICKS - 1);

    // every key edge restarts the shared counter, so a coincident tick is lost to both phases
    morse_tick_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (rise | fall),
        .en  (tick && state != IDLE),
        .cnt (cnt)
    );

    // phase FSM with registered pulses and the symbol shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            key_d          <= 1'b0;
            symbol_valid   <= 1'b0;
            symbol_is_dash <= 1'b0;
            code           <= '0;
            code_len       <= '0;
            letter_valid   <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            key_d        <= key_in;
            symbol_valid <= 1'b0;
            overflow     <= 1'b0;
            letter_valid <= 1'b0;
            if (letter_valid) begin
                code     <= '0;
                code_len <= '0;
            end
            case (state)
                IDLE: if (rise) state <= PRESS;
                PRESS: if (fall) begin
                    state          <= GAP;
                    symbol_valid   <= 1'b1;
                    symbol_is_dash <= is_dash;
                    if (code_len == 3'(MAX_SYMBOLS)) overflow <= 1'b1;
                    else begin
                        code[code_len] <= is_dash;
                        code_len       <= code_len + 3'd1;
                    end
                end
                GAP: if (rise) state <= PRESS;
                else if (gap_done) begin
                    state        <= IDLE;
                    letter_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: directed scenarios for the Morse key decoder with a tick every 10 clocks
module tb_morse_key_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       key_in = 1'b0;
    logic       symbol_valid;
    logic       symbol_is_dash;
    logic [4:0] code;
    logic [2:0] code_len;
    logic       letter_valid;
    logic       overflow;

    int total = 0;
    int bad = 0;

    int nsym = 0;
    int ndash = 0;
    int nlet = 0;
    int novf = 0;
    int ovf_sym = 0;
    logic [4:0] let_code = '0;
    logic [2:0] let_len = '0;
    logic [7:0] hist = '0;
    logic pend = 1'b0;
    logic clr_ok = 1'b0;

    morse_key_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .key_in         (key_in),
        .symbol_valid   (symbol_valid),
        .symbol_is_dash (symbol_is_dash),
        .code           (code),
        .code_len       (code_len),
        .letter_valid   (letter_valid),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pend) clr_ok <= (code == 5'd0 && code_len == 3'd0);
        pend <= letter_valid;
        if (symbol_valid) begin
            nsym  <= nsym + 1;
            ndash <= ndash + int'(symbol_is_dash);
            hist  <= {hist[6:0], symbol_is_dash};
        end
        if (overflow) begin
            novf    <= novf + 1;
            ovf_sym <= nsym + 1;
        end
        if (letter_valid) begin
            nlet     <= nlet + 1;
            let_code <= code;
            let_len  <= code_len;
        end
    end

    task automatic step(input logic k, input logic t);
        key_in = k;
        tick = t;
        @(negedge clk);
    endtask

    task automatic run(input logic k, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 9; j++) step(k, 1'b0);
            step(k, 1'b1);
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        total++;
        if ({symbol_valid, symbol_is_dash, code, code_len, letter_valid, overflow} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {symbol_valid, symbol_is_dash, code, code_len, letter_valid, overflow});
        end
        rst = 1'b0;
        settle();
    endtask

    task automatic test_single_dot();
        int s0 = nsym, l0 = nlet, d0 = ndash;
        run(1'b1, 1);
        run(1'b0, 3);
        settle();
        total++;
        if (nsym - s0 !== 1 || ndash - d0 !== 0) begin
            bad++;
            $display("FAIL e_symbols: got %0d syms %0d dashes want 1 and 0", nsym - s0, ndash - d0);
        end
        total++;
        if (nlet - l0 !== 1 || let_code !== 5'b00000 || let_len !== 3'd1) begin
            bad++;
            $display("FAIL e_letter: got n=%0d code=%b len=%0d want n=1 code=00000 len=1", nlet - l0, let_code, let_len);
        end
        total++;
        if (clr_ok !== 1'b1) begin
            bad++;
            $display("FAIL e_clear_after: got %b want 1", clr_ok);
        end
    endtask

    task automatic test_letter_b();
        int s0 = nsym, l0 = nlet;
        run(1'b1, 4);
        run(1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            run(1'b1, 1);
            run(1'b0, (i == 2) ? 3 : 1);
        end
        settle();
        total++;
        if (nsym - s0 !== 4 || hist[3:0] !== 4'b1000) begin
            bad++;
            $display("FAIL b_symbols: got n=%0d seq=%b want n=4 seq=1000", nsym - s0, hist[3:0]);
        end
        total++;
        if (nlet - l0 !== 1 || let_code !== 5'b00001 || let_len !== 3'd4) begin
            bad++;
            $display("FAIL b_letter: got n=%0d code=%b len=%0d want n=1 code=00001 len=4", nlet - l0, let_code, let_len);
        end
    endtask

    task automatic test_overflow();
        int s0 = nsym, l0 = nlet, o0 = novf;
        for (int i = 0; i < 6; i++) begin
            run(1'b1, 1);
            run(1'b0, (i == 5) ? 3 : 1);
        end
        settle();
        total++;
        if (novf - o0 !== 1 || ovf_sym - s0 !== 6) begin
            bad++;
            $display("FAIL ovf_pulse: got count=%0d at sym %0d want 1 at 6", novf - o0, ovf_sym - s0);
        end
        total++;
        if (nsym - s0 !== 6) begin
            bad++;
            $display("FAIL ovf_symbols: got %0d want 6", nsym - s0);
        end
        total++;
        if (nlet - l0 !== 1 || let_code !== 5'b00000 || let_len !== 3'd5) begin
            bad++;
            $display("FAIL ovf_letter: got n=%0d code=%b len=%0d want n=1 code=00000 len=5", nlet - l0, let_code, let_len);
        end
    endtask

    task automatic test_saturate();
        int l0 = nlet;
        run(1'b1, 20);
        total++;
        if (dut.u_cnt.cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_count: got %0d want 15", dut.u_cnt.cnt);
        end
        run(1'b0, 3);
        settle();
        total++;
        if (hist[0] !== 1'b1 || nlet - l0 !== 1 || let_code !== 5'b00001 || let_len !== 3'd1) begin
            bad++;
            $display("FAIL sat_dash: got dash=%b n=%0d code=%b len=%0d want 1 1 00001 1", hist[0], nlet - l0, let_code, let_len);
        end
    endtask

    task automatic test_threshold();
        int s0 = nsym, l0 = nlet;
        run(1'b1, 2);
        run(1'b0, 1);
        run(1'b1, 3);
        run(1'b0, 1);
        run(1'b1, 2);
        for (int j = 0; j < 9; j++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        run(1'b0, 3);
        settle();
        total++;
        if (nsym - s0 !== 3 || hist[2:0] !== 3'b010) begin
            bad++;
            $display("FAIL thr_symbols: got n=%0d seq=%b want n=3 seq=010", nsym - s0, hist[2:0]);
        end
        total++;
        if (nlet - l0 !== 1 || let_code !== 5'b00010 || let_len !== 3'd3) begin
            bad++;
            $display("FAIL thr_letter: got n=%0d code=%b len=%0d want n=1 code=00010 len=3", nlet - l0, let_code, let_len);
        end
    endtask

    task automatic test_mid_reset();
        int s0 = nsym, l0 = nlet;
        run(1'b1, 1);
        run(1'b0, 1);
        run(1'b1, 1);
        run(1'b0, 1);
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        total++;
        if (code !== 5'd0 || code_len !== 3'd0 || letter_valid !== 1'b0 || symbol_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_outputs: got code=%b len=%0d lv=%b sv=%b want all 0", code, code_len, letter_valid, symbol_valid);
        end
        run(1'b0, 5);
        total++;
        if (nlet - l0 !== 0 || nsym - s0 !== 2) begin
            bad++;
            $display("FAIL rst_no_letter: got letters=%0d syms=%0d want 0 and 2", nlet - l0, nsym - s0);
        end
        run(1'b1, 1);
        run(1'b0, 3);
        settle();
        total++;
        if (nlet - l0 !== 1 || let_len !== 3'd1 || let_code !== 5'd0) begin
            bad++;
            $display("FAIL rst_after: got n=%0d code=%b len=%0d want n=1 code=00000 len=1", nlet - l0, let_code, let_len);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_dot();
        test_letter_b();
        test_overflow();
        test_saturate();
        test_threshold();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
